// File: rtl/delay_line_receiver.sv
// delay_line_receiver
//   Receive-side terminator for a fixed-latency, non-stallable delay line.
//   Words leaving the line are captured in a small FIFO and presented as a
//   ready/valid stream downstream logic may stall. Loss is prevented by a
//   credit scheme: the launch end may inject a word only when a FIFO slot
//   is reserved for it (count + inflight < DEPTH).
//
// Parameters
//   WIDTH  data width in bits
//   DELAY  latency of the delay line (full rate needs DEPTH >= DELAY+2)
//   DEPTH  FIFO entries, >= 1, any value (no power-of-2 restriction)
//
// Ports
//   Clock       rising-edge clock
//   Reset       asynchronous active-high reset
//   IssueValid  launch end wants to inject a word this cycle
//   IssueReady  a credit is available; launch = IssueValid && IssueReady
//   InData      word arriving from the delay line
//   InValid     InData is valid this cycle
//   OutData     head-of-FIFO word (first-word fall-through)
//   OutValid    FIFO not empty
//   OutReady    downstream accepts OutData this cycle
//   Overflow    sticky error flag, cleared only by Reset
//   Occupancy   current FIFO entry count
module delay_line_receiver #(
   parameter int WIDTH = 32,
   parameter int DELAY = 1,
   parameter int DEPTH = 4
) (
   input  logic                           Clock,
   input  logic                           Reset,
   input  logic                           IssueValid,
   output logic                           IssueReady,
   input  logic [WIDTH-1:0]               InData,
   input  logic                           InValid,
   output logic [WIDTH-1:0]               OutData,
   output logic                           OutValid,
   input  logic                           OutReady,
   output logic                           Overflow,
   output logic [$clog2(DEPTH+1)-1:0]     Occupancy
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   // Elaboration-time parameter sanity
   if (DEPTH < 1) begin : g_bad_depth
      $error("delay_line_receiver: DEPTH must be at least 1");
   end
   if (DEPTH < DELAY + 2) begin : g_low_depth
      $warning("delay_line_receiver: DEPTH below DELAY+2 limits throughput");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr_r, wr_ptr_r, rd_ptr_nx_s, wr_ptr_nx_s;
   logic [CW-1:0]    count_r, inflight_r, count_nx_s, inflight_nx_s;
   logic             issue_ready_r, issue_ready_nx_s;
   logic             out_valid_r, overflow_r;
   logic             launch_s, pop_s, push_ok_s, ovf_set_s;

   // Pointer advance with wrap at DEPTH-1 (works for any DEPTH)
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      if (ptr == LAST_PTR) begin
         next_ptr = '0;
      end else begin
         next_ptr = ptr + PW'(1);
      end
   endfunction

   // Handshake decode and next-state computation
   always_comb begin
      launch_s  = IssueValid && issue_ready_r;
      pop_s     = out_valid_r && OutReady;
      // At full, a same-cycle pop frees the slot the arriving word takes
      push_ok_s = InValid && ((count_r != DEPTH_C) || pop_s);
      // Arrival with nothing in flight, or a dropped word, is an error
      ovf_set_s = InValid && ((inflight_r == '0) || !push_ok_s);

      count_nx_s = count_r;
      if (push_ok_s && !pop_s) begin
         count_nx_s = count_r + CW'(1);
      end else if (!push_ok_s && pop_s) begin
         count_nx_s = count_r - CW'(1);
      end else begin
         count_nx_s = count_r;
      end

      // Unexpected arrivals leave inflight saturated at zero
      inflight_nx_s = inflight_r + CW'(launch_s);
      if (InValid && (inflight_r != '0)) begin
         inflight_nx_s = inflight_nx_s - CW'(1);
      end else begin
         inflight_nx_s = inflight_nx_s;
      end

      rd_ptr_nx_s = pop_s     ? next_ptr(rd_ptr_r) : rd_ptr_r;
      wr_ptr_nx_s = push_ok_s ? next_ptr(wr_ptr_r) : wr_ptr_r;

      // Credit for next cycle from next registered values; compared in a
      // wider sum so misuse of the line cannot wrap the credit count
      issue_ready_nx_s = ({1'b0, count_nx_s} + {1'b0, inflight_nx_s}) < {1'b0, DEPTH_C};
   end

   // Control state and registered flags
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rd_ptr_r      <= '0;
         wr_ptr_r      <= '0;
         count_r       <= '0;
         inflight_r    <= '0;
         issue_ready_r <= 1'b1;
         out_valid_r   <= 1'b0;
         overflow_r    <= 1'b0;
      end else begin
         rd_ptr_r      <= rd_ptr_nx_s;
         wr_ptr_r      <= wr_ptr_nx_s;
         count_r       <= count_nx_s;
         inflight_r    <= inflight_nx_s;
         issue_ready_r <= issue_ready_nx_s;
         out_valid_r   <= (count_nx_s != '0);
         overflow_r    <= overflow_r || ovf_set_s;
      end
   end

   // FIFO storage; contents need no reset since OutValid qualifies them
   always_ff @(posedge Clock) begin
      if (push_ok_s) begin
         mem[wr_ptr_r] <= InData;
      end
   end

   assign IssueReady = issue_ready_r;
   assign OutValid   = out_valid_r;
   assign OutData    = mem[rd_ptr_r];
   assign Overflow   = overflow_r;
   assign Occupancy  = count_r;

endmodule

// File: tb/tb_delay_line_receiver.sv
// Directed bench for delay_line_receiver. Instance A: DEPTH=4, DELAY=2,
// fed by a two-stage delay line model. Instance B: DEPTH=3, DELAY=1.
module tb_delay_line_receiver;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   int n_cmp = 0;
   int n_bad = 0;

   // Instance A signals
   logic        a_iv, a_ir, a_inv, a_ov, a_or, a_ovf;
   logic [31:0] a_ind, a_od;
   logic [2:0]  a_occ;
   logic        a_force;
   logic [31:0] a_force_d;
   logic        a_l0_v, a_l1_v;
   logic [31:0] a_l0_d, a_l1_d, a_word;
   int          a_launches;

   // Instance B signals
   logic        b_iv, b_ir, b_inv, b_ov, b_or, b_ovf;
   logic [31:0] b_ind, b_od;
   logic [1:0]  b_occ;
   logic        b_l0_v;
   logic [31:0] b_l0_d, b_word;
   int          b_launches;

   delay_line_receiver #(.WIDTH(32), .DELAY(2), .DEPTH(4)) dut_a (
      .Clock(clk), .Reset(rst), .IssueValid(a_iv), .IssueReady(a_ir),
      .InData(a_ind), .InValid(a_inv), .OutData(a_od), .OutValid(a_ov),
      .OutReady(a_or), .Overflow(a_ovf), .Occupancy(a_occ));

   delay_line_receiver #(.WIDTH(32), .DELAY(1), .DEPTH(3)) dut_b (
      .Clock(clk), .Reset(rst), .IssueValid(b_iv), .IssueReady(b_ir),
      .InData(b_ind), .InValid(b_inv), .OutData(b_od), .OutValid(b_ov),
      .OutReady(b_or), .Overflow(b_ovf), .Occupancy(b_occ));

   // Launch end plus two-cycle delay line for instance A
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         a_l0_v <= 1'b0; a_l1_v <= 1'b0; a_l0_d <= 32'd0; a_l1_d <= 32'd0;
         a_word <= 32'd0; a_launches <= 0;
      end else begin
         a_l0_v <= a_iv && a_ir;
         a_l0_d <= a_word;
         a_l1_v <= a_l0_v;
         a_l1_d <= a_l0_d;
         if (a_iv && a_ir) begin
            a_word     <= a_word + 32'd1;
            a_launches <= a_launches + 1;
         end
      end
   end
   assign a_inv = a_force ? 1'b1 : a_l1_v;
   assign a_ind = a_force ? a_force_d : a_l1_d;

   // Launch end plus one-cycle delay line for instance B
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         b_l0_v <= 1'b0; b_l0_d <= 32'd0; b_word <= 32'hA0; b_launches <= 0;
      end else begin
         b_l0_v <= b_iv && b_ir;
         b_l0_d <= b_word;
         if (b_iv && b_ir) begin
            b_word     <= b_word + 32'd1;
            b_launches <= b_launches + 1;
         end
      end
   end
   assign b_inv = b_l0_v;
   assign b_ind = b_l0_d;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [31:0] drain_exp [4];
      int got, first_cyc, last_cyc, l0, occ_max;
      drain_exp[0] = 32'd22; drain_exp[1] = 32'd23;
      drain_exp[2] = 32'd24; drain_exp[3] = 32'h55;

      rst = 1'b1;
      a_iv = 1'b0; a_or = 1'b0; a_force = 1'b0; a_force_d = 32'd0;
      b_iv = 1'b0; b_or = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_a_ready", a_ir, 32'd1);
      check("rst_a_valid", a_ov, 32'd0);
      check("rst_a_occ", a_occ, 32'd0);
      check("rst_a_ovf", a_ovf, 32'd0);
      check("rst_b_ready", b_ir, 32'd1);
      check("rst_b_valid", b_ov, 32'd0);
      rst = 1'b0;

      // Reset mid-operation: reach count=3, inflight=1, then async reset
      a_iv = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (a_occ == 3'd3) break;
      end
      a_iv = 1'b0;
      check("mid_pre_occ", a_occ, 32'd3);
      check("mid_pre_ready", a_ir, 32'd0);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_ready", a_ir, 32'd1);
      check("mid_rst_valid", a_ov, 32'd0);
      check("mid_rst_occ", a_occ, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Streaming: 20 words, OutReady held high
      a_or = 1'b1;
      got = 0; first_cyc = -1; last_cyc = -1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         a_iv = (cyc < 20);
         if (cyc < 20) check("stream_ready", a_ir, 32'd1);
         if (a_ov) begin
            check("stream_data", a_od, 32'(got));
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            got++;
         end
         @(negedge clk);
      end
      a_iv = 1'b0;
      check("stream_count", 32'(got), 32'd20);
      check("stream_back_to_back", 32'(last_cyc - first_cyc), 32'd19);
      check("stream_ovf", a_ovf, 32'd0);

      // Backpressure: OutReady low, IssueValid held high
      a_or = 1'b0;
      l0 = a_launches;
      a_iv = 1'b1;
      repeat (12) @(negedge clk);
      check("bp_launches", 32'(a_launches - l0), 32'd4);
      check("bp_ready_low", a_ir, 32'd0);
      check("bp_occ", a_occ, 32'd4);
      check("bp_head", a_od, 32'd20);
      a_or = 1'b1;
      check("bp_pop_cycle_ready", a_ir, 32'd0);
      @(negedge clk);
      a_or = 1'b0;
      check("bp_after_pop_ready", a_ir, 32'd1);
      check("bp_after_pop_occ", a_occ, 32'd3);
      check("bp_after_pop_head", a_od, 32'd21);
      @(negedge clk);
      a_iv = 1'b0;
      check("bp_refill_launch", 32'(a_launches - l0), 32'd5);
      check("bp_refill_ready", a_ir, 32'd0);
      repeat (3) @(negedge clk);
      check("bp_refill_occ", a_occ, 32'd4);

      // Full with simultaneous push/pop (forced arrival, inflight==0)
      a_force = 1'b1; a_force_d = 32'h55; a_or = 1'b1;
      @(negedge clk);
      a_force = 1'b0; a_or = 1'b0;
      check("full_pp_occ", a_occ, 32'd4);
      check("full_pp_head", a_od, 32'd22);
      check("full_pp_ovf_arrival", a_ovf, 32'd1);
      a_or = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("full_pp_drain_valid", a_ov, 32'd1);
         check("full_pp_drain_data", a_od, drain_exp[k]);
         @(negedge clk);
      end
      a_or = 1'b0;
      check("full_pp_empty", a_ov, 32'd0);

      // Overflow: clean start, fill via credits, then force a drop
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("ovf_cleared", a_ovf, 32'd0);
      a_iv = 1'b1;
      repeat (12) @(negedge clk);
      a_iv = 1'b0;
      check("ovf_fill_occ", a_occ, 32'd4);
      check("ovf_fill_flag", a_ovf, 32'd0);
      a_force = 1'b1; a_force_d = 32'hEE;
      @(negedge clk);
      a_force = 1'b0;
      check("ovf_set", a_ovf, 32'd1);
      check("ovf_occ", a_occ, 32'd4);
      repeat (5) @(negedge clk);
      check("ovf_sticky", a_ovf, 32'd1);
      a_or = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("ovf_drain_data", a_od, 32'(k));
         @(negedge clk);
      end
      a_or = 1'b0;
      check("ovf_dropped_word", a_ov, 32'd0);
      check("ovf_sticky_after_drain", a_ovf, 32'd1);
      #1 rst = 1'b1;
      #1;
      check("ovf_reset_clear", a_ovf, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Wrap-around on DEPTH=3 with random OutReady
      got = 0; occ_max = 0;
      for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
         b_iv = (b_launches < 10);
         b_or = 1'($urandom_range(0, 1));
         if (int'(b_occ) > occ_max) occ_max = int'(b_occ);
         if (b_ov && b_or) begin
            check("wrap_data", b_od, 32'hA0 + 32'(got));
            got++;
         end
         @(negedge clk);
      end
      b_iv = 1'b0; b_or = 1'b0;
      @(negedge clk);
      check("wrap_count", 32'(got), 32'd10);
      check("wrap_occ_max_ok", 32'(occ_max <= 3), 32'd1);
      check("wrap_ovf", b_ovf, 32'd0);
      check("wrap_empty", b_ov, 32'd0);
      check("wrap_occ_zero", b_occ, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
